reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each register in bits.
REQ-002 SHALL have parameter ADDR_W, default 2: register address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write register index.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port rd_en  input  1  read request for both read ports.
REQ-010 SHALL have port rd_addr_1  input  ADDR_W  read port 1 index.
REQ-011 SHALL have port rd_addr_2  input  ADDR_W  read port 2 index.
REQ-012 SHALL have port rd_data_1  output  DATA_W  registered read port 1 data.
REQ-013 SHALL have port rd_data_2  output  DATA_W  registered read port 2 data.
REQ-014 SHALL have port rd_valid  output  1  rd_data_1/2 updated by an accepted read on the previous edge.
REQ-015 SHALL have port lock_en  input  1  marks lock_addr as pending, i.e. awaiting a future write.
REQ-016 SHALL have port lock_addr  input  ADDR_W  register index to lock.
REQ-017 SHALL have port busy  output  DEPTH  per-register pending bits, registered.
REQ-018 SHALL have port stall  output  1  combinational; the current read request is refused.

Function
REQ-019 SHALL store DEPTH registers of DATA_W bits; all ports are fully independent in the same cycle.
REQ-020 SHALL write wr_data into register wr_addr on a rising edge with wr_en=1.
REQ-021 SHALL, when ZERO_REG=1, ignore writes and locks to address 0, so that reads of address 0 return 0 and busy[0] stays 0.
REQ-022 SHALL compute stall = rd_en & ((busy[rd_addr_1] & ~hit_1) | (busy[rd_addr_2] & ~hit_2)), where hit_n = wr_en & (wr_addr == rd_addr_n) & (write not ignored per REQ-021).
REQ-023 SHALL accept a read when rd_en=1 and stall=0, and on that edge load rd_data_n with the value of register rd_addr_n, giving 1-cycle latency.
REQ-024 SHALL, when hit_n is true for an accepted read, load rd_data_n with wr_data instead (write-first bypass); both ports may bypass simultaneously.
REQ-025 SHALL set rd_valid to 1 on the edge after an accepted read and to 0 otherwise.
REQ-026 SHALL hold rd_data_1/2 at their last values when no read is accepted; they never go X.
REQ-027 SHALL set busy[lock_addr] on an edge with lock_en=1.
REQ-028 SHALL clear busy[wr_addr] on an edge with wr_en=1.
REQ-029 SHALL leave busy set when lock and write target the same address on the same edge, because the lock wins and a new pending write is opened.
REQ-030 SHALL apply writes and reads to the same lock/busy state snapshot: stall uses busy before the edge's updates.
REQ-031 SHALL allow writes to a non-busy register, which leave busy unchanged (busy[wr_addr] stays 0).

Reset
REQ-032 SHALL, while rst=1, asynchronously clear all registers, busy, rd_data_1, rd_data_2 and rd_valid to 0.
REQ-033 SHALL force stall to 0 while rst=1.
REQ-034 SHALL, when rst is asserted mid-operation, discard the in-flight read (rd_valid=0) and lose all pending locks.
REQ-035 SHALL ignore all requests on the first edge with rst=1 and resume normal operation on the first edge after rst deasserts.

Verification
REQ-036 SHALL cover basic read/write: write 0xA5 to reg 2, then one cycle later rd_en with rd_addr_1=2, rd_addr_2=0 -> next cycle rd_data_1=0xA5, rd_data_2=0x00, rd_valid=1.
REQ-037 SHALL cover bypass: same-edge wr_en (addr 1, 0x3C) and rd_en (both ports addr 1) -> rd_data_1=rd_data_2=0x3C next cycle.
REQ-038 SHALL cover the scoreboard: lock reg 3, then rd_en addr 3 -> stall=1 and rd_valid=0 with rd_data held; write 0x77 to reg 3 in the same cycle as the read -> stall=0, rd_data_1=0x77, busy[3]=0.
REQ-039 SHALL cover simultaneous lock and write: lock_en and wr_en to reg 1 with 0x11 -> reg 1=0x11 and busy[1]=1.
REQ-040 SHALL cover the zero register: with ZERO_REG=1, write 0xFF to reg 0 and lock reg 0 -> read returns 0x00, busy[0]=0, stall=0.
REQ-041 SHALL cover mid-operation reset: regs loaded, busy=4'b0110, rd_en active, then pulse rst between edges -> immediately all outputs, busy and stall are 0, and subsequent reads return 0x00.

Source files
------------

// File: rtl/reg_file.sv
// Multi-ported register file: one write port and two registered read ports.
// A per-register busy scoreboard refuses reads of registers that are still awaiting a write.
module reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_valid,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [DEPTH-1:0]  busy,
  output logic              stall
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_1_q, rd_data_1_d;
  logic [DATA_W-1:0] rd_data_2_q, rd_data_2_d;
  logic              rd_valid_q;

  logic wr_ok, lock_ok, hit_1, hit_2, rd_acc;

  // Address 0 swallows writes and locks when it is the hardwired zero register.
  assign wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr   == '0));
  assign lock_ok = lock_en && !((ZERO_REG != 0) && (lock_addr == '0));

  assign hit_1 = wr_ok && (wr_addr == rd_addr_1);
  assign hit_2 = wr_ok && (wr_addr == rd_addr_2);

  // A same-edge write to a busy register satisfies the pending read through the bypass.
  assign stall  = !rst && rd_en &&
                  ((busy_q[rd_addr_1] && !hit_1) || (busy_q[rd_addr_2] && !hit_2));
  assign rd_acc = rd_en && !stall;

  assign rd_data_1_d = hit_1 ? wr_data : regs_q[rd_addr_1];
  assign rd_data_2_d = hit_2 ? wr_data : regs_q[rd_addr_2];

  // The lock is applied after the write clear so it wins on the same address.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (lock_ok) begin
      busy_d[lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
      busy_q     <= busy_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_1_q <= rd_data_1_d;
        rd_data_2_q <= rd_data_2_d;
      end
    end
  end

  assign rd_data_1 = rd_data_1_q;
  assign rd_data_2 = rd_data_2_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: two instances (ZERO_REG=0 and ZERO_REG=1) share the stimulus,
// directed steps push hand-computed read results, negedge monitors pop and compare.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, lock_en;
  logic [1:0] wr_addr, rd_addr_1, rd_addr_2, lock_addr;
  logic [7:0] wr_data;

  logic [7:0] a_rd_data_1, a_rd_data_2, z_rd_data_1, z_rd_data_2;
  logic       a_rd_valid, z_rd_valid, a_stall, z_stall;
  logic [3:0] a_busy, z_busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_z[$];

  always #5 clk = ~clk;

  reg_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(a_rd_data_1), .rd_data_2(a_rd_data_2), .rd_valid(a_rd_valid),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(a_busy), .stall(a_stall)
  );

  reg_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(z_rd_data_1), .rd_data_2(z_rd_data_2), .rd_valid(z_rd_valid),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(z_busy), .stall(z_stall)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic re, input logic [1:0] r1, input logic [1:0] r2,
                       input logic le, input logic [1:0] la);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_1 = r1; rd_addr_2 = r2;
    lock_en = le; lock_addr = la;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input string name, input logic [3:0] ea, input logic [3:0] ez);
    chk({name, "_busy_a"}, 16'(a_busy), 16'(ea));
    chk({name, "_busy_z"}, 16'(z_busy), 16'(ez));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data_a"}, {a_rd_data_1, a_rd_data_2}, 16'h0000);
    chk({name, "_data_z"}, {z_rd_data_1, z_rd_data_2}, 16'h0000);
    chk({name, "_ctl_a"}, {13'h0, a_rd_valid, a_stall, 1'b0}, 16'h0000);
    chk({name, "_ctl_z"}, {13'h0, z_rd_valid, z_stall, 1'b0}, 16'h0000);
    chk_busy(name, 4'b0000, 4'b0000);
  endtask

  // Monitors: every presented read result must match the oldest expected entry.
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (exp_a.size() == 0) chk("a_unexpected_valid", 16'h1, 16'h0);
      else chk("a_rd_data", {a_rd_data_1, a_rd_data_2}, exp_a.pop_front());
    end
    if (z_rd_valid) begin
      if (exp_z.size() == 0) chk("z_unexpected_valid", 16'h1, 16'h0);
      else chk("z_rd_data", {z_rd_data_1, z_rd_data_2}, exp_z.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held across two edges while every request is active.
    rst = 1'b1;
    drive(1'b1, 2'd2, 8'hEE, 1'b1, 2'd2, 2'd2, 1'b1, 2'd1);
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset_edges");
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();

    // Basic write then read.
    drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd0, 1'b0, 2'd0);
    exp_a.push_back(16'hA500); exp_z.push_back(16'hA500);
    tick();

    // Write-first bypass on both ports.
    drive(1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0);
    exp_a.push_back(16'h3C3C); exp_z.push_back(16'h3C3C);
    tick();

    // Lock reg 3, then a refused read, then a read satisfied by a same-edge write.
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
    tick();
    chk_busy("lock3", 4'b1000, 4'b1000);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
    #1;
    chk("stall_locked_a", 16'(a_stall), 16'h1);
    chk("stall_locked_z", 16'(z_stall), 16'h1);
    tick();
    chk("refused_valid_a", 16'(a_rd_valid), 16'h0);
    chk("refused_hold_a", {a_rd_data_1, a_rd_data_2}, 16'h3C3C);
    chk("refused_hold_z", {z_rd_data_1, z_rd_data_2}, 16'h3C3C);
    drive(1'b1, 2'd3, 8'h77, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
    #1;
    chk("stall_bypass_a", 16'(a_stall), 16'h0);
    exp_a.push_back(16'h7700); exp_z.push_back(16'h7700);
    tick();
    chk_busy("wr3", 4'b0000, 4'b0000);

    // Lock and write to the same register: lock wins.
    drive(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1);
    tick();
    chk_busy("lockwr1", 4'b0010, 4'b0010);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0);
    #1;
    chk("stall_reg1_a", 16'(a_stall), 16'h1);
    tick();
    chk("stall_reg1_valid", 16'(a_rd_valid), 16'h0);

    // Zero register: write and lock to address 0.
    drive(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0);
    tick();
    chk_busy("zero", 4'b0011, 4'b0010);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0);
    #1;
    chk("stall_zero_a", 16'(a_stall), 16'h1);
    chk("stall_zero_z", 16'(z_stall), 16'h0);
    exp_z.push_back(16'h00A5);
    tick();
    drive(1'b1, 2'd0, 8'h55, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("stall_wr0_a", 16'(a_stall), 16'h0);
    chk("stall_wr0_z", 16'(z_stall), 16'h0);
    exp_a.push_back(16'h5555); exp_z.push_back(16'h0000);
    tick();
    chk_busy("wr0", 4'b0010, 4'b0010);

    // Mid-operation reset with busy=0110 and a read outstanding.
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    tick();
    chk_busy("lock2", 4'b0110, 4'b0110);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
    exp_a.push_back(16'h7755); exp_z.push_back(16'h7700);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0);
    #1;
    chk("stall_prerst_a", 16'(a_stall), 16'h1);
    #4;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    #1;
    chk("stall_postrst_a", 16'(a_stall), 16'h0);
    exp_a.push_back(16'h0000); exp_z.push_back(16'h0000);
    tick();
    chk_busy("postrst", 4'b0000, 4'b0000);

    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    tick();
    chk("a_queue_left", 16'(exp_a.size()), 16'h0);
    chk("z_queue_left", 16'(exp_z.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
